// File: rtl/adc_spi_if.sv
// Pin and parallel-side bundle between an ADC SPI initiator and the ADC responder.
// The slave modport is the responder's view; the master modport is the initiator/test side.
interface adc_spi_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned NUM_CH = 8
);
    logic                       adc_cs_n;
    logic                       adc_sclk;
    logic                       adc_saddr;
    logic                       adc_sdat;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic [2:0]                 cur_ch;
    logic                       busy;
    logic                       frame_done;
    logic                       frame_error;

    modport slave (
        input  adc_cs_n, adc_sclk, adc_saddr, ch_data,
        output adc_sdat, cur_ch, busy, frame_done, frame_error
    );

    modport master (
        output adc_cs_n, adc_sclk, adc_saddr, ch_data,
        input  adc_sdat, cur_ch, busy, frame_done, frame_error
    );
endinterface

// File: rtl/adc_spi_responder.sv
// Emulates an 8-channel 12-bit serial ADC (ADC128S022 framing) on oversampled SPI pins.
// The address sent in one frame selects the channel returned in the following frame.
module adc_spi_responder #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset,
    adc_spi_if.slave  io_spi
);
    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    state_e                 r_state, w_state_d;
    logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_saddr_sync, r_fill;
    logic                   r_cs_dly, r_sclk_dly, r_armed;
    logic [15:0]            r_shreg;
    logic [4:0]             r_rise_cnt;
    logic [2:0]             r_addr_tmp, r_cur_ch;
    logic                   r_frame_done, r_frame_error;

    logic w_cs, w_sclk, w_saddr, w_sync_valid;
    logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
    logic w_load, w_rise_inc, w_shift, w_done, w_err;
    logic [DATA_W-1:0] w_ch_sel;
    logic [11:0]       w_sample;

    assign w_cs         = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_saddr      = r_saddr_sync[SYNC_STAGES-1];
    // Last sync stage holds a real pin sample, not a reset-loaded 1.
    assign w_sync_valid = r_fill[SYNC_STAGES-1];
    assign w_cs_fall    = r_cs_dly & ~w_cs;
    assign w_cs_rise    = ~r_cs_dly & w_cs;
    assign w_sclk_rise  = ~r_sclk_dly & w_sclk;
    assign w_sclk_fall  = r_sclk_dly & ~w_sclk;

    always_comb begin
        w_ch_sel = '0;
        if (32'(r_cur_ch) < NUM_CH) begin
            w_ch_sel = io_spi.ch_data[32'(r_cur_ch)*DATA_W +: DATA_W];
        end
    end

    if (DATA_W >= 12) begin : g_trunc
        assign w_sample = w_ch_sel[11:0];
    end else begin : g_zext
        assign w_sample = {{(12-DATA_W){1'b0}}, w_ch_sel};
    end

    always_comb begin
        w_state_d  = r_state;
        w_load     = 1'b0;
        w_rise_inc = 1'b0;
        w_shift    = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_cs_fall && r_armed) begin
                    w_load    = 1'b1;
                    w_state_d = StActive;
                end
            end
            StActive: begin
                // The 16th rise beats a coincident CS rise.
                if (w_sclk_rise && r_rise_cnt == 5'd15) begin
                    w_rise_inc = 1'b1;
                    w_done     = 1'b1;
                    w_state_d  = StDone;
                end else if (w_cs_rise) begin
                    w_err     = 1'b1;
                    w_state_d = StIdle;
                end else if (w_sclk_rise) begin
                    w_rise_inc = 1'b1;
                end else if (w_sclk_fall && r_rise_cnt != 5'd0) begin
                    w_shift = 1'b1;
                end
            end
            StDone: begin
                // Level test so a CS rise consumed on the done cycle still exits.
                if (w_cs) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync     <= '1;
            r_sclk_sync   <= '1;
            r_saddr_sync  <= '1;
            r_fill        <= '0;
            r_cs_dly      <= 1'b1;
            r_sclk_dly    <= 1'b1;
            r_armed       <= 1'b0;
            r_state       <= StIdle;
            r_shreg       <= '0;
            r_rise_cnt    <= '0;
            r_addr_tmp    <= '0;
            r_cur_ch      <= '0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], io_spi.adc_cs_n};
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], io_spi.adc_sclk};
            r_saddr_sync  <= {r_saddr_sync[SYNC_STAGES-2:0], io_spi.adc_saddr};
            r_fill        <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_cs_dly      <= w_cs;
            r_sclk_dly    <= w_sclk;
            r_state       <= w_state_d;
            r_frame_done  <= w_done;
            r_frame_error <= w_err;
            if (w_sync_valid && w_cs) begin
                r_armed <= 1'b1;
            end
            if (w_load) begin
                r_shreg    <= {4'b0000, w_sample};
                r_rise_cnt <= '0;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[14:0], 1'b0};
            end
            if (w_rise_inc) begin
                r_rise_cnt <= r_rise_cnt + 5'd1;
                if (r_rise_cnt >= 5'd2 && r_rise_cnt <= 5'd4) begin
                    r_addr_tmp <= {r_addr_tmp[1:0], w_saddr};
                end
            end
            if (w_done) begin
                r_cur_ch <= r_addr_tmp;
            end
        end
    end

    assign io_spi.adc_sdat    = (r_state != StIdle) ? r_shreg[15] : 1'b0;
    assign io_spi.cur_ch      = r_cur_ch;
    assign io_spi.busy        = (r_state != StIdle);
    assign io_spi.frame_done  = r_frame_done;
    assign io_spi.frame_error = r_frame_error;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI frames and checks DOUT words and status.
module tb_adc_spi_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   chg_rise = 0;
    int   chg_ch = 0;
    logic [11:0] chg_val = '0;
    logic [15:0] rd;
    int   d0, e0;

    adc_spi_if #(.DATA_W(12), .NUM_CH(8)) spi ();

    adc_spi_responder #(.DATA_W(12), .NUM_CH(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_spi (spi)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (spi.frame_done)  done_cnt <= done_cnt + 1;
        if (spi.frame_error) err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (10) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [11:0] v);
        spi.ch_data[c*12 +: 12] = v;
    endtask

    // One frame; nrise<16 aborts by raising CS after that many rises.
    task automatic run_frame(input logic [2:0] addr, input bit cpol, input int nrise,
                             input int extra, input bit exp_hold, input bit coinc,
                             output logic [15:0] word);
        word = '0;
        spi.adc_sclk  = cpol;
        spi.adc_saddr = 1'b0;
        half();
        spi.adc_cs_n = 1'b0;
        half();
        for (int k = 1; k <= nrise; k++) begin
            spi.adc_sclk  = 1'b0;
            spi.adc_saddr = (k == 3) ? addr[2] : (k == 4) ? addr[1] : (k == 5) ? addr[0] : 1'b0;
            if (k == chg_rise) set_ch(chg_ch, chg_val);
            half();
            word[16-k] = spi.adc_sdat;
            spi.adc_sclk = 1'b1;
            if (coinc && k == nrise) spi.adc_cs_n = 1'b1;
            half();
        end
        for (int e = 0; e < extra; e++) begin
            spi.adc_sclk = 1'b0;
            half();
            check("hold_lo", {31'd0, spi.adc_sdat}, {31'd0, exp_hold});
            spi.adc_sclk = 1'b1;
            half();
            check("hold_hi", {31'd0, spi.adc_sdat}, {31'd0, exp_hold});
        end
        if (!cpol) begin
            spi.adc_sclk = 1'b0;
            half();
        end
        spi.adc_cs_n = 1'b1;
        half();
        half();
    endtask

    initial begin
        spi.adc_cs_n  = 1'b1;
        spi.adc_sclk  = 1'b1;
        spi.adc_saddr = 1'b0;
        spi.ch_data   = '0;
        set_ch(0, 12'hABC);
        set_ch(1, 12'h456);
        set_ch(3, 12'hFFF);
        set_ch(5, 12'h123);
        set_ch(6, 12'h9E7);
        repeat (5) @(negedge clk);
        check("rst_sdat", {31'd0, spi.adc_sdat}, 32'd0);
        check("rst_cur_ch", {29'd0, spi.cur_ch}, 32'd0);
        check("rst_busy", {31'd0, spi.busy}, 32'd0);
        check("rst_pulses", {30'd0, spi.frame_done, spi.frame_error}, 32'd0);
        reset = 1'b0;
        half();

        // Frame 1: first frame returns channel 0, selects 5.
        d0 = done_cnt; e0 = err_cnt;
        run_frame(3'd5, 1'b1, 16, 0, 1'b0, 1'b0, rd);
        check("f1_word", {16'd0, rd}, 32'h0ABC);
        check("f1_done", done_cnt - d0, 1);
        check("f1_err", err_cnt - e0, 0);
        check("f1_cur_ch", {29'd0, spi.cur_ch}, 5);
        check("f1_busy", {31'd0, spi.busy}, 0);

        // Frame 2: returns channel 5, selects 1.
        run_frame(3'd1, 1'b1, 16, 0, 1'b0, 1'b0, rd);
        check("f2_word", {16'd0, rd}, 32'h0123);
        check("f2_cur_ch", {29'd0, spi.cur_ch}, 1);

        // Aborted after 9 rises with address 3.
        d0 = done_cnt; e0 = err_cnt;
        run_frame(3'd3, 1'b1, 9, 0, 1'b0, 1'b0, rd);
        check("ab_err", err_cnt - e0, 1);
        check("ab_done", done_cnt - d0, 0);
        check("ab_cur_ch", {29'd0, spi.cur_ch}, 1);

        // Returns old channel 1, selects 3.
        run_frame(3'd3, 1'b1, 16, 0, 1'b0, 1'b0, rd);
        check("f4_word", {16'd0, rd}, 32'h0456);
        check("f4_cur_ch", {29'd0, spi.cur_ch}, 3);

        // CPOL=0 with 4 extra pulses after rise 16; DB0 of 0xFFF is 1.
        d0 = done_cnt;
        run_frame(3'd2, 1'b0, 16, 4, 1'b1, 1'b0, rd);
        check("f5_word", {16'd0, rd}, 32'h0FFF);
        check("f5_done", done_cnt - d0, 1);
        check("f5_cur_ch", {29'd0, spi.cur_ch}, 2);

        // ch2 changes mid-frame; the change shows only in the next frame.
        set_ch(2, 12'h555);
        chg_rise = 8; chg_ch = 2; chg_val = 12'hAAA;
        run_frame(3'd2, 1'b1, 16, 0, 1'b0, 1'b0, rd);
        chg_rise = 0;
        check("f6_word", {16'd0, rd}, 32'h0555);
        run_frame(3'd6, 1'b1, 16, 0, 1'b0, 1'b0, rd);
        check("f7_word", {16'd0, rd}, 32'h0AAA);
        check("f7_cur_ch", {29'd0, spi.cur_ch}, 6);

        // Reset mid-frame with CS held low; ch6=0x9E7 so 4 shifts expose bit 11 = 1.
        d0 = done_cnt;
        spi.adc_sclk = 1'b1;
        half();
        spi.adc_cs_n = 1'b0;
        half();
        check("mr_busy", {31'd0, spi.busy}, 1);
        for (int p = 0; p < 5; p++) begin
            spi.adc_sclk = 1'b0; half();
            spi.adc_sclk = 1'b1; half();
        end
        check("mr_sdat_pre", {31'd0, spi.adc_sdat}, 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_sdat_rst", {31'd0, spi.adc_sdat}, 0);
        check("mr_busy_rst", {31'd0, spi.busy}, 0);
        check("mr_cur_ch_rst", {29'd0, spi.cur_ch}, 0);
        spi.adc_sclk = 1'b0; half();
        spi.adc_sclk = 1'b1; half();
        reset = 1'b0;
        for (int p = 0; p < 3; p++) begin
            spi.adc_sclk = 1'b0; half();
            spi.adc_sclk = 1'b1; half();
        end
        check("mr_busy_post", {31'd0, spi.busy}, 0);
        check("mr_sdat_post", {31'd0, spi.adc_sdat}, 0);
        check("mr_no_done", done_cnt - d0, 0);
        spi.adc_cs_n = 1'b1;
        half();

        // Normal frame after reset returns channel 0.
        run_frame(3'd6, 1'b1, 16, 0, 1'b0, 1'b0, rd);
        check("f8_word", {16'd0, rd}, 32'h0ABC);
        check("f8_cur_ch", {29'd0, spi.cur_ch}, 6);

        // CS rise coincident with the 16th SCLK rise.
        d0 = done_cnt; e0 = err_cnt;
        run_frame(3'd4, 1'b1, 16, 0, 1'b0, 1'b1, rd);
        check("co_word", {16'd0, rd}, 32'h09E7);
        check("co_done", done_cnt - d0, 1);
        check("co_err", err_cnt - e0, 0);
        check("co_cur_ch", {29'd0, spi.cur_ch}, 4);
        check("co_busy", {31'd0, spi.busy}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI responder that emulates the board's 8-channel, 12-bit serial ADC (ADC128S022 frame format).
- Connects to the imu_controller_0 ADC pins (CS_N, SCLK, SADDR in; SDAT out) in place of the physical ADC, for hardware-in-the-loop sensor injection and bring-up.
- Per-channel sample values come from a parallel input bus driven by a test source or the Nios.
- Runs entirely in the clk domain; the SPI inputs are oversampled.

Parameters:
- DATA_W, 12, sample width per channel in bits.
- NUM_CH, 8, number of channels; address width is fixed at 3.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (minimum 2).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- adc_cs_n  input  1  frame select from the initiator, active low.
- adc_sclk  input  1  serial clock from the initiator.
- adc_saddr  input  1  serial address/control (DIN) from the initiator.
- adc_sdat  output  1  serial data (DOUT) to the initiator.
- ch_data  input  NUM_CH*DATA_W  channel samples; channel n occupies bits [n*DATA_W +: DATA_W].
- cur_ch  output  3  channel to be returned in the next frame.
- busy  output  1  high while a frame is in progress (ACTIVE or DONE).
- frame_done  output  1  one-cycle pulse when a complete 16-bit frame finishes.
- frame_error  output  1  one-cycle pulse when CS deasserts before the frame completes.

Behaviour:
- Reset: all synchronizer flops load 1, adc_sdat=0, cur_ch=0, busy=0, frame_done=0, frame_error=0, rise_cnt=0, state=IDLE.
- After reset, no frame is accepted until synchronized CS has been seen high at least once (arm flag).
- Each of cs_n, sclk and saddr passes through SYNC_STAGES flops. Edge detection compares the last sync stage with a one-cycle-delayed copy.
- Reaction latency is SYNC_STAGES+1 clk cycles from a pin edge to the resulting adc_sdat change. Required SCLK half-period is at least SYNC_STAGES+2 clk cycles; faster SCLK is unsupported (no detection required).
- State IDLE:
  - adc_sdat=0.
  - On a CS falling edge while armed: load shreg[15:0] = {4'b0, ch_data[cur_ch]}, zero-extended or truncated to 12 bits; rise_cnt=0; busy=1; go to ACTIVE.
- adc_sdat = shreg[15] whenever the state is not IDLE.
- State ACTIVE:
  - SCLK rising edge: increment rise_cnt. On rises 3, 4 and 5, shift sync saddr into addr_tmp MSB-first (ADD2, ADD1, ADD0).
  - SCLK falling edge with rise_cnt >= 1: shreg <= shreg << 1, filling 0. A falling edge before the first rise is ignored, so both SCLK idle levels work.
  - On rise 16: cur_ch <= addr_tmp, frame_done pulses, go to DONE.
  - CS rising edge in ACTIVE: frame_error pulses, cur_ch unchanged, go to IDLE.
- State DONE:
  - SCLK edges are ignored; adc_sdat holds the last bit (DB0 shifted).
  - On a CS rising edge, go to IDLE with busy=0 and no pulse.
- Simultaneous events:
  - If the CS rising edge and the 16th SCLK rising edge are detected in the same cycle, the SCLK edge wins: frame_done pulses and state goes to DONE. The next cycle sees CS high and goes to IDLE.
  - CS falling and SCLK edges in the same cycle: the load takes priority and the SCLK edge is discarded.
- ch_data is sampled only at the frame-start load. Changes mid-frame do not affect the current frame.
- Address semantics: the address in frame N selects the data returned in frame N+1. The first frame after reset returns channel 0.
- Reset mid-frame: the block returns to IDLE, adc_sdat=0, and arm is cleared. CS must go high before the next frame.

Test Plan:
- Reset, ch_data ch0=0xABC, ch5=0x123. Frame 1 (CPOL=1, 16 clocks, half-period 10 clk) sends saddr bits 3-5 = 101 -> DOUT reads 0x0ABC, frame_done pulses once, cur_ch=5. Frame 2 reads 0x0123.
- CS raised after 9 rising edges with saddr = 011 -> frame_error pulses, frame_done stays 0, cur_ch stays at its prior value, and the next frame returns the old channel.
- CPOL=0 (SCLK idle low), ch3=0xFFF preselected -> reads 0x0FFF. CS held low for 4 extra SCLK pulses after rise 16 -> DOUT constant, no second frame_done.
- ch_data changed from 0x555 to 0xAAA at rise 8 of a frame -> that frame reads 0x0555, the next frame reads 0x0AAA.
- Reset asserted mid-frame with CS held low -> adc_sdat=0, busy=0, SCLK ignored. CS high then low -> normal frame returns channel 0.
- CS rise coincident with the 16th detected SCLK rise -> frame_done=1, frame_error=0, cur_ch updated.
